// File: rtl/prog_counter_pkg.sv
// Shared types for the programmable counter: counting modes and one-shot run states.
package prog_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        OS_IDLE    = 2'd0,
        OS_RUN     = 2'd1,
        OS_EXPIRED = 2'd2
    } os_state_e;

endpackage

// File: rtl/step_prescaler.sv
// Rate divider: raises step on every (prescale+1)-th enabled cycle; any gap in enable restarts the count.
module step_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [PRE_W-1:0] prescale,
    output logic             step
);

    logic [PRE_W-1:0] pre_cnt_r;

    assign step = enable && (pre_cnt_r == prescale);

    // Enabled-cycle counter, restarted on clear, idle enable or an issued step.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_r <= '0;
        end else if (clear || !enable || step) begin
            pre_cnt_r <= '0;
        end else begin
            pre_cnt_r <= pre_cnt_r + {{(PRE_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Bounded up/down counter with prescaler and WRAP / SAT / ONESHOT modes.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             direction,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] min_value,
    input  logic [WIDTH-1:0] max_value,
    input  logic [PRE_W-1:0] prescale,
    input  logic             start,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             done,
    output logic             busy
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    mode_e            mode_s;
    mode_e            mode_prev_r;
    os_state_e        state_r;
    os_state_e        state_nxt_s;
    logic             mode_chg_s;
    logic             start_acc_s;
    logic             step_s;
    logic             at_bound_s;
    logic [WIDTH-1:0] far_s;
    logic [WIDTH-1:0] near_s;
    logic [WIDTH-1:0] step_val_s;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic             tc_nxt_s;
    logic             busy_nxt_s;

    assign mode_s      = mode_e'(mode);
    assign mode_chg_s  = (mode_s != mode_prev_r);
    assign start_acc_s = start && (mode_s == MODE_ONESHOT) && !mode_chg_s;

    // Out-of-range counts compare as already sitting on the bound.
    assign at_bound_s = direction ? (counter >= max_value) : (counter <= min_value);
    assign done       = at_bound_s;
    assign far_s      = direction ? max_value : min_value;
    assign near_s     = direction ? min_value : max_value;
    assign step_val_s = direction ? (counter + CNT_ONE) : (counter - CNT_ONE);

    step_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .clear    (load || start_acc_s),
        .prescale (prescale),
        .step     (step_s)
    );

    // Next count, terminal pulse and one-shot state; load beats start beats step.
    always_comb begin
        cnt_nxt_s   = counter;
        tc_nxt_s    = 1'b0;
        state_nxt_s = state_r;
        busy_nxt_s  = busy;
        if (load) begin
            cnt_nxt_s   = load_value;
            state_nxt_s = OS_IDLE;
            busy_nxt_s  = 1'b0;
        end else if (mode_s == MODE_ONESHOT) begin
            if (mode_chg_s) begin
                state_nxt_s = OS_IDLE;
                busy_nxt_s  = 1'b0;
            end else if (start) begin
                cnt_nxt_s   = near_s;
                state_nxt_s = OS_RUN;
                busy_nxt_s  = 1'b1;
            end else if (step_s && (state_r == OS_RUN)) begin
                if (at_bound_s || (step_val_s == far_s)) begin
                    cnt_nxt_s   = at_bound_s ? counter : step_val_s;
                    state_nxt_s = OS_EXPIRED;
                    tc_nxt_s    = 1'b1;
                    busy_nxt_s  = 1'b0;
                end else begin
                    cnt_nxt_s = step_val_s;
                end
            end else begin
                cnt_nxt_s = counter;
            end
        end else begin
            state_nxt_s = OS_IDLE;
            busy_nxt_s  = 1'b0;
            if (step_s) begin
                if (at_bound_s) begin
                    tc_nxt_s  = 1'b1;
                    cnt_nxt_s = (mode_s == MODE_WRAP) ? near_s : counter;
                end else begin
                    cnt_nxt_s = step_val_s;
                end
            end else begin
                cnt_nxt_s = counter;
            end
        end
    end

    // Output and state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter     <= '0;
            tc          <= 1'b0;
            busy        <= 1'b0;
            state_r     <= OS_IDLE;
            mode_prev_r <= mode_s;
        end else begin
            counter     <= cnt_nxt_s;
            tc          <= tc_nxt_s;
            busy        <= busy_nxt_s;
            state_r     <= state_nxt_s;
            mode_prev_r <= mode_s;
        end
    end

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: directed scenarios then randomized traffic against a behavioural model.
module tb_prog_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       load;
    logic [7:0] load_value;
    logic       direction;
    logic [1:0] mode;
    logic [7:0] min_value;
    logic [7:0] max_value;
    logic [3:0] prescale;
    logic       start;
    logic [7:0] counter;
    logic       tc;
    logic       done;
    logic       busy;

    prog_counter #(.WIDTH(8), .PRE_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .direction  (direction),
        .mode       (mode),
        .min_value  (min_value),
        .max_value  (max_value),
        .prescale   (prescale),
        .start      (start),
        .counter    (counter),
        .tc         (tc),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit tc;
        bit busy;
        bit done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    int   cyc_no = 0;

    // configuration held between cycles
    bit       cfg_dir = 1'b1;
    int       cfg_mode = 0;
    int       cfg_min = 0;
    int       cfg_max = 255;
    int       cfg_ps = 0;

    // behavioural model state
    int m_cnt = 0;
    int m_pre = 0;
    int m_prev_mode = 0;
    bit m_tc = 1'b0;
    bit m_running = 1'b0;

    function automatic bit at_bound(int c);
        return cfg_dir ? (c >= cfg_max) : (c <= cfg_min);
    endfunction

    task automatic chk(string name, int act, int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc_no, act, req);
    endtask

    task automatic model_cycle(bit r, bit en, bit ld, int lv, bit st);
        bit step;
        bit chg;
        bit st_ok;
        int far_b;
        int near_b;
        exp_t e;
        if (r) begin
            m_cnt = 0; m_tc = 1'b0; m_running = 1'b0; m_pre = 0; m_prev_mode = cfg_mode;
        end else begin
            step  = en && (m_pre == cfg_ps);
            chg   = (cfg_mode != m_prev_mode);
            m_prev_mode = cfg_mode;
            st_ok = st && (cfg_mode == 2) && !ld && !chg;
            if (!en || ld || st_ok || step) m_pre = 0;
            else m_pre = m_pre + 1;
            far_b  = cfg_dir ? cfg_max : cfg_min;
            near_b = cfg_dir ? cfg_min : cfg_max;
            m_tc = 1'b0;
            if (ld) begin
                m_cnt = lv; m_running = 1'b0;
            end else if (cfg_mode == 2) begin
                if (chg) m_running = 1'b0;
                else if (st) begin
                    m_cnt = near_b; m_running = 1'b1;
                end else if (step && m_running) begin
                    if (!at_bound(m_cnt)) m_cnt = cfg_dir ? m_cnt + 1 : m_cnt - 1;
                    if (at_bound(m_cnt)) begin
                        m_running = 1'b0; m_tc = 1'b1;
                    end
                end
            end else begin
                m_running = 1'b0;
                if (step) begin
                    if (at_bound(m_cnt)) begin
                        m_tc = 1'b1;
                        if (cfg_mode == 0) m_cnt = near_b;
                    end else begin
                        m_cnt = cfg_dir ? m_cnt + 1 : m_cnt - 1;
                    end
                end
            end
        end
        e.cnt = m_cnt; e.tc = m_tc; e.busy = m_running; e.done = at_bound(m_cnt);
        exp_q.push_back(e);
        // expected counter must stay a valid 8-bit value
        if (m_cnt < 0 || m_cnt > 255) $display("FAIL model_range cycle %0d: got %0d expected 0..255", cyc_no, m_cnt);
    endtask

    // Drive one cycle of stimulus at the falling edge and record the model's prediction.
    task automatic cyc(bit r, bit en, bit ld, int lv, bit st);
        @(negedge clk);
        cyc_no++;
        rst = r; enable = en; load = ld; load_value = lv[7:0]; start = st;
        direction = cfg_dir; mode = cfg_mode[1:0];
        min_value = cfg_min[7:0]; max_value = cfg_max[7:0]; prescale = cfg_ps[3:0];
        model_cycle(r, en, ld, lv, st);
    endtask

    task automatic set_cfg(bit dir, int md, int mn, int mx, int ps);
        cfg_dir = dir; cfg_mode = md; cfg_min = mn; cfg_max = mx; cfg_ps = ps;
    endtask

    // Monitor: compare every registered result just after the rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("counter", int'(counter), mon_e.cnt);
            chk("tc", int'(tc), int'(mon_e.tc));
            chk("busy", int'(busy), int'(mon_e.busy));
            chk("done", int'(done), int'(mon_e.done));
        end
    end

    initial begin
        int mn;
        int mx;
        rst = 1'b1; enable = 1'b0; load = 1'b0; load_value = 8'd0; start = 1'b0;
        direction = 1'b1; mode = 2'd0; min_value = 8'd0; max_value = 8'd255; prescale = 4'd0;

        set_cfg(1'b1, 0, 0, 255, 0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 0, 1'b0);

        // WRAP up 3..6
        set_cfg(1'b1, 0, 3, 6, 0);
        cyc(1'b0, 1'b0, 1'b1, 3, 1'b0);
        repeat (6) cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);

        // SAT down 2..9
        set_cfg(1'b0, 1, 2, 9, 0);
        cyc(1'b0, 1'b0, 1'b1, 4, 1'b0);
        repeat (4) cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);

        // prescale 2, WRAP up 0..255, then a one-cycle enable gap
        set_cfg(1'b1, 0, 0, 255, 2);
        cyc(1'b0, 1'b0, 1'b1, 0, 1'b0);
        repeat (9) cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);

        // ONESHOT up 0..3, expire, hold, restart
        set_cfg(1'b1, 2, 0, 3, 0);
        cyc(1'b0, 1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 0, 1'b1);
        repeat (5) cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 0, 1'b1);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);

        // load and start together
        cyc(1'b0, 1'b1, 1'b1, 10, 1'b1);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);

        // reset mid-run, then a clean run
        cyc(1'b0, 1'b1, 1'b0, 0, 1'b1);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 0, 1'b1);
        repeat (4) cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);

        // min == max in WRAP and ONESHOT
        set_cfg(1'b1, 0, 5, 5, 0);
        cyc(1'b0, 1'b0, 1'b1, 5, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
        set_cfg(1'b0, 2, 5, 5, 0);
        cyc(1'b0, 1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 0, 1'b1);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                mn = $urandom_range(0, 255);
                mx = ($urandom_range(0, 1) == 0) ? $urandom_range(mn, (mn + 8 > 255) ? 255 : mn + 8)
                                                 : $urandom_range(mn, 255);
                set_cfg(cfg_dir, $urandom_range(0, 3), mn, mx, $urandom_range(0, 3));
            end
            if ($urandom_range(0, 14) == 0) cfg_dir = ~cfg_dir;
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 24) == 0),
                $urandom_range(0, 255),
                ($urandom_range(0, 11) == 0));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
